// File: rtl/bvshl_pkg.sv
// Shared types and the golden bvshl model for the shared shift-left evaluator.
package bvshl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int unsigned REF_W = 64;

    // SMT-LIB bvshl on a w-bit vector: shift amounts >= w give zero.
    function automatic logic [REF_W-1:0] bvshl_ref(
        input logic [REF_W-1:0] a,
        input logic [REF_W-1:0] s,
        input int unsigned      w
    );
        logic [REF_W-1:0] mask;
        mask = {REF_W{1'b1}} >> (REF_W - w);
        if (s >= REF_W'(w)) begin
            return '0;
        end
        return (a << s) & mask;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; the owner updates the pointer on accept.
module rr_arb2 (
    input  logic [1:0] i_valid,
    input  logic       i_ptr,
    output logic [1:0] o_grant
);

    always_comb begin
        o_grant = 2'b00;
        case (i_valid)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = i_ptr ? 2'b10 : 2'b01;
            default: o_grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/bvshl_eq_sched.sv
// Two requesters share one iterative shifter computing r = a << s (bvshl)
// and eq = (r == t); the result is held with the owner's id until taken.
module bvshl_eq_sched
    import bvshl_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [1:0]     req_valid,
    output logic [1:0]     req_ready,
    input  logic [2*W-1:0] req_a,
    input  logic [2*W-1:0] req_s,
    input  logic [2*W-1:0] req_t,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           out_id,
    output logic [W-1:0]   out_r,
    output logic           out_eq
);

    localparam int unsigned CW = $clog2(W + 1);
    localparam int unsigned XW = W + 1;

    state_t         r_state;
    state_t         w_state_nxt;
    logic           r_rr_ptr;
    logic [CW-1:0]  r_cnt;
    logic [W-1:0]   r_acc;
    logic [W-1:0]   r_t;
    logic           r_id;

    logic [1:0]     w_grant;
    logic           w_accept;
    logic           w_sel_id;
    logic [W-1:0]   w_sel_a;
    logic [W-1:0]   w_sel_s;
    logic [W-1:0]   w_sel_t;
    logic           w_s_big;

    rr_arb2 u_arb (
        .i_valid (req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant)
    );

    // Payload of the granted requester; ignored unless accepted.
    assign w_accept = (r_state == IDLE) && (w_grant != 2'b00);
    assign w_sel_id = w_grant[1];
    assign w_sel_a  = w_sel_id ? req_a[2*W-1:W] : req_a[W-1:0];
    assign w_sel_s  = w_sel_id ? req_s[2*W-1:W] : req_s[W-1:0];
    assign w_sel_t  = w_sel_id ? req_t[2*W-1:W] : req_t[W-1:0];
    assign w_s_big  = XW'(w_sel_s) >= XW'(W);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = SHIFT;
            SHIFT:   if (r_cnt == '0) w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = 2'b00;
        if (r_state == IDLE) begin
            req_ready = w_grant;
        end
    end

    // Datapath: capture on accept, shift one bit per cycle, publish result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr  <= 1'b0;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_t       <= '0;
            r_id      <= 1'b0;
            out_valid <= 1'b0;
            out_id    <= 1'b0;
            out_r     <= '0;
            out_eq    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_t      <= w_sel_t;
                        r_id     <= w_sel_id;
                        r_rr_ptr <= ~w_sel_id;
                        if (w_s_big) begin
                            r_acc <= '0;
                            r_cnt <= '0;
                        end else begin
                            r_acc <= w_sel_a;
                            r_cnt <= w_sel_s[CW-1:0];
                        end
                    end
                end
                SHIFT: begin
                    if (r_cnt != '0) begin
                        r_acc <= {r_acc[W-2:0], 1'b0};
                        r_cnt <= r_cnt - CW'(1);
                    end else begin
                        out_r     <= r_acc;
                        out_eq    <= (r_acc == r_t);
                        out_id    <= r_id;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
